// File: rtl/gcd_stein.sv
// Binary (Stein) GCD engine with tagged request/response handshakes.
// Latency: 1 cycle for a zero operand, else 1 + up to 2*XLEN+1 CALC cycles.
// Backpressure: req_rdy only in IDLE; the response is held in DONE until resp_rdy.
module gcd_stein #(
    parameter int XLEN = 16,
    parameter int TAGW = 4,
    parameter int CNTW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2*XLEN-1:0] req_msg,
    input  logic [TAGW-1:0]   req_tag,
    input  logic              req_val,
    output logic              req_rdy,
    output logic [XLEN-1:0]   resp_msg,
    output logic [TAGW-1:0]   resp_tag,
    output logic [CNTW-1:0]   resp_cycles,
    output logic              resp_val,
    input  logic              resp_rdy
);

    localparam int SW = $clog2(XLEN) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] a_r;
    logic [XLEN-1:0] b_r;
    logic [SW-1:0]   shift_r;
    logic [CNTW-1:0] cyc_r;
    logic [TAGW-1:0] tag_r;
    logic [XLEN-1:0] res_r;

    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;

    assign req_a = req_msg[2*XLEN-1:XLEN];
    assign req_b = req_msg[XLEN-1:0];

    assign req_rdy     = (state == IDLE);
    assign resp_val    = (state == DONE);
    assign resp_msg    = res_r;
    assign resp_tag    = tag_r;
    assign resp_cycles = cyc_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            shift_r <= '0;
            cyc_r   <= '0;
            tag_r   <= '0;
            res_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        a_r     <= req_a;
                        b_r     <= req_b;
                        tag_r   <= req_tag;
                        shift_r <= '0;
                        cyc_r   <= '0;
                        if ((req_a == '0) || (req_b == '0)) begin
                            res_r <= req_a | req_b;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (cyc_r != {CNTW{1'b1}})
                        cyc_r <= cyc_r + CNTW'(1);
                    // Common factor of two is restored at the end; gcd <= min(a,b) so no overflow.
                    if (a_r == b_r) begin
                        res_r <= a_r << shift_r;
                        state <= DONE;
                    end else if (!a_r[0] && !b_r[0]) begin
                        a_r     <= a_r >> 1;
                        b_r     <= b_r >> 1;
                        shift_r <= shift_r + SW'(1);
                    end else if (!a_r[0]) begin
                        a_r <= a_r >> 1;
                    end else if (!b_r[0]) begin
                        b_r <= b_r >> 1;
                    end else if (a_r > b_r) begin
                        a_r <= (a_r - b_r) >> 1;
                    end else begin
                        b_r <= (b_r - a_r) >> 1;
                    end
                end
                DONE: begin
                    if (resp_rdy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stein.sv
// Directed bench for gcd_stein: hand-computed GCD vectors, zero/equal operands,
// response backpressure, and reset during a computation.
module tb_gcd_stein;

    localparam int XLEN = 16;
    localparam int TAGW = 4;
    localparam int CNTW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [2*XLEN-1:0] req_msg;
    logic [TAGW-1:0]   req_tag;
    logic              req_val;
    logic              req_rdy;
    logic [XLEN-1:0]   resp_msg;
    logic [TAGW-1:0]   resp_tag;
    logic [CNTW-1:0]   resp_cycles;
    logic              resp_val;
    logic              resp_rdy;

    int n_checks = 0;
    int n_errors = 0;

    gcd_stein #(.XLEN(XLEN), .TAGW(TAGW), .CNTW(CNTW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_msg     (req_msg),
        .req_tag     (req_tag),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .resp_msg    (resp_msg),
        .resp_tag    (resp_tag),
        .resp_cycles (resp_cycles),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp_cyc / exp_lat of -1 mean "not checked"; resp_rdy is assumed high.
    task automatic do_req(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [TAGW-1:0] t, input logic [XLEN-1:0] exp,
                          input int exp_cyc, input int exp_lat);
        int wait_n;
        int lat;
        wait_n = 0;
        while (!req_rdy && wait_n < 100) begin
            tick();
            wait_n++;
        end
        chk("req_rdy_wait", {31'd0, req_rdy}, 32'd1);
        req_msg = {a, b};
        req_tag = t;
        req_val = 1'b1;
        tick();
        req_val = 1'b0;
        lat = 0;
        while (!resp_val && lat < 100) begin
            tick();
            lat++;
        end
        chk("resp_val_seen", {31'd0, resp_val}, 32'd1);
        chk("resp_msg", {16'd0, resp_msg}, {16'd0, exp});
        chk("resp_tag", {28'd0, resp_tag}, {28'd0, t});
        chk("cyc_bound", {31'd0, (resp_cycles <= 8'(2*XLEN+1))}, 32'd1);
        if (exp_cyc >= 0) chk("resp_cycles", {24'd0, resp_cycles}, exp_cyc);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
        tick();
        chk("post_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("post_resp_val", {31'd0, resp_val}, 32'd0);
    endtask

    initial begin
        int ones;
        int lat;
        reset    = 1'b1;
        req_val  = 1'b1;
        req_msg  = {16'd48, 16'd18};
        req_tag  = 4'd7;
        resp_rdy = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        req_val = 1'b0;
        chk("rst_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("rst_resp_val", {31'd0, resp_val}, 32'd0);
        chk("rst_resp_msg", {16'd0, resp_msg}, 32'd0);
        chk("rst_resp_tag", {28'd0, resp_tag}, 32'd0);
        chk("rst_resp_cyc", {24'd0, resp_cycles}, 32'd0);

        do_req(16'd48, 16'd18, 4'd3, 16'd6, 6, -1);

        do_req(16'd1701,  16'd199,   4'd1, 16'd1,    -1, -1);
        do_req(16'd22000, 16'd19900, 4'd2, 16'd100,  -1, -1);
        do_req(16'd42000, 16'd1990,  4'd3, 16'd10,   -1, -1);
        do_req(16'd17,    16'd289,   4'd4, 16'd17,   -1, -1);
        do_req(16'd40664, 16'd57408, 4'd5, 16'd2392, -1, -1);

        do_req(16'd0,  16'd35, 4'd6, 16'd35, 0, 0);
        do_req(16'd35, 16'd0,  4'd7, 16'd35, 0, 0);
        do_req(16'd0,  16'd0,  4'd8, 16'd0,  0, 0);

        do_req(16'd21,    16'd21,    4'd9,  16'd21,    1, -1);
        do_req(16'd65535, 16'd65535, 4'd10, 16'd65535, 1, -1);

        // Backpressure with a competing request held on the input.
        resp_rdy = 1'b0;
        req_msg  = {16'd48, 16'd18};
        req_tag  = 4'd11;
        req_val  = 1'b1;
        tick();
        req_msg  = {16'd100, 16'd75};
        req_tag  = 4'd12;
        lat = 0;
        while (!resp_val && lat < 100) begin
            tick();
            lat++;
        end
        chk("bp_resp_val_seen", {31'd0, resp_val}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_resp_val", {31'd0, resp_val}, 32'd1);
            chk("bp_resp_msg", {16'd0, resp_msg}, 32'd6);
            chk("bp_resp_tag", {28'd0, resp_tag}, 32'd11);
            chk("bp_resp_cyc", {24'd0, resp_cycles}, 32'd6);
            chk("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
            tick();
        end
        resp_rdy = 1'b1;
        tick();
        req_val = 1'b0;
        chk("bp_after_req_rdy", {31'd0, req_rdy}, 32'd1);
        chk("bp_after_resp_val", {31'd0, resp_val}, 32'd0);
        tick();
        chk("bp_no_accept", {31'd0, req_rdy}, 32'd1);

        // Reset after three CALC cycles discards the computation.
        req_msg = {16'd40664, 16'd57408};
        req_tag = 4'd13;
        req_val = 1'b1;
        tick();
        req_val = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_req_rdy", {31'd0, req_rdy}, 32'd1);
        ones = 0;
        for (int i = 0; i < 60; i++) begin
            if (resp_val) ones++;
            tick();
        end
        chk("midrst_no_resp", ones, 0);
        do_req(16'd12, 16'd8, 4'd14, 16'd4, 5, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gcd_stein.md
GCD_STEIN -- requirements
Module: gcd_stein

Interface
REQ-001 SHALL have parameter XLEN, default 16, operand and result width in bits.
REQ-002 SHALL have parameter TAGW, default 4, request/response tag width.
REQ-003 SHALL have parameter CNTW, default 8, width of the response cycle-count field.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_msg  input  2*XLEN  operands; a = req_msg[2*XLEN-1:XLEN], b = req_msg[XLEN-1:0].
REQ-007 SHALL have port req_tag  input  TAGW  request identifier.
REQ-008 SHALL have port req_val  input  1  request valid.
REQ-009 SHALL have port req_rdy  output  1  block can accept a request.
REQ-010 SHALL have port resp_msg  output  XLEN  gcd(a,b).
REQ-011 SHALL have port resp_tag  output  TAGW  tag of the accepted request.
REQ-012 SHALL have port resp_cycles  output  CNTW  cycles spent in CALC for this result.
REQ-013 SHALL have port resp_val  output  1  response valid.
REQ-014 SHALL have port resp_rdy  input  1  consumer ready.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-016 Handshake: transfer occurs on a rising edge where val and rdy are both high; val SHALL not depend combinationally on rdy.
REQ-017 req_rdy SHALL be 1 only in IDLE; resp_val SHALL be 1 only in DONE.
REQ-018 IDLE accept: latch a, b, req_tag; clear shift counter and cycle counter.
REQ-019 IDLE accept with a==0 or b==0: result = a|b (0 if both zero), resp_cycles = 0, next state DONE (latency 1 cycle).
REQ-020 IDLE accept with both nonzero: next state CALC.
REQ-021 CALC each cycle, priority order: a==b -> result = a << shift, next DONE; both even -> a>>=1, b>>=1, shift+=1; a even -> a>>=1; b even -> b>>=1; both odd, a>b -> a=(a-b)>>1; both odd, a<b -> b=(b-a)>>1.
REQ-022 Cycle counter SHALL increment on every CALC cycle including the terminal a==b cycle, saturating at 2^CNTW-1.
REQ-023 Shift counter SHALL be wide enough for XLEN; a<<shift SHALL be computed in XLEN bits (cannot overflow since gcd <= min(a,b)).
REQ-024 DONE: resp_msg, resp_tag, resp_cycles held stable while resp_val=1 and resp_rdy=0.
REQ-025 DONE with resp_rdy=1: next state IDLE; no request is accepted in that same cycle.
REQ-026 Iterations for nonzero operands SHALL not exceed 2*XLEN+1 CALC cycles.
REQ-027 req_val while not in IDLE SHALL be ignored; the requester must hold it until req_rdy.

Reset
REQ-028 reset=1 at a rising edge SHALL force IDLE regardless of state, discarding any computation or pending response.
REQ-029 Reset values: resp_val=0, resp_msg=0, resp_tag=0, resp_cycles=0, req_rdy=1 in the first cycle after reset deasserts.
REQ-030 A request presented during reset SHALL not be accepted.

Verification
REQ-031 a=48, b=18, tag=3, resp_rdy=1 -> resp_msg=6, resp_tag=3, resp_cycles=6.
REQ-032 Sequence (1701,199), (22000,19900), (42000,1990), (17,289), (40664,57408) -> 1, 100, 10, 17, 2392, tags in order.
REQ-033 Zero operands: (0,35) -> 35; (35,0) -> 35; (0,0) -> 0; each with resp_cycles=0 and resp_val exactly one cycle after accept.
REQ-034 Equal operands (21,21) -> resp_msg=21, resp_cycles=1; (65535,65535) -> 65535.
REQ-035 Backpressure: (48,18) with resp_rdy=0 for 10 cycles after resp_val -> outputs stable, req_rdy=0 throughout; result taken on resp_rdy=1; req_rdy=1 the next cycle.
REQ-036 Reset mid-CALC on (40664,57408) after 3 CALC cycles -> resp_val never asserts; a following (12,8) -> 4.
